// File: rtl/register_bank32.sv
// 32 x WIDTH register storage; r0 reads as zero, r28/r29 reset to gp/sp pointers.
// Optional WRITE_FWD_EN: a committing write shows on its q output in the same cycle.
module register_bank32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE = 5,
    parameter logic [WIDTH-1:0] GP_INIT = 32'h1000_8000,
    parameter logic [WIDTH-1:0] SP_INIT = 32'h7FFF_EFFC
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [SIZE-1:0]  wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] q0_o,
    output logic [WIDTH-1:0] q1_o,
    output logic [WIDTH-1:0] q2_o,
    output logic [WIDTH-1:0] q3_o,
    output logic [WIDTH-1:0] q4_o,
    output logic [WIDTH-1:0] q5_o,
    output logic [WIDTH-1:0] q6_o,
    output logic [WIDTH-1:0] q7_o,
    output logic [WIDTH-1:0] q8_o,
    output logic [WIDTH-1:0] q9_o,
    output logic [WIDTH-1:0] q10_o,
    output logic [WIDTH-1:0] q11_o,
    output logic [WIDTH-1:0] q12_o,
    output logic [WIDTH-1:0] q13_o,
    output logic [WIDTH-1:0] q14_o,
    output logic [WIDTH-1:0] q15_o,
    output logic [WIDTH-1:0] q16_o,
    output logic [WIDTH-1:0] q17_o,
    output logic [WIDTH-1:0] q18_o,
    output logic [WIDTH-1:0] q19_o,
    output logic [WIDTH-1:0] q20_o,
    output logic [WIDTH-1:0] q21_o,
    output logic [WIDTH-1:0] q22_o,
    output logic [WIDTH-1:0] q23_o,
    output logic [WIDTH-1:0] q24_o,
    output logic [WIDTH-1:0] q25_o,
    output logic [WIDTH-1:0] q26_o,
    output logic [WIDTH-1:0] q27_o,
    output logic [WIDTH-1:0] q28_o,
    output logic [WIDTH-1:0] q29_o,
    output logic [WIDTH-1:0] q30_o,
    output logic [WIDTH-1:0] q31_o,
    output logic [15:0]      wr_count_o,
    output logic [SIZE-1:0]  last_wr_addr_o
);
    localparam int unsigned NumRegs = 32;

    logic [WIDTH-1:0] regs_q [NumRegs];
    logic [WIDTH-1:0] regs_d [NumRegs];
    logic [WIDTH-1:0] rd     [NumRegs];
    logic [15:0]      wr_count_q, wr_count_d;
    logic [SIZE-1:0]  last_wr_addr_q, last_wr_addr_d;
    logic             wr_commit;

    // Writes to r0 are dropped entirely, including the bookkeeping.
    assign wr_commit = wr_en_i && (wr_addr_i != '0);

    always_comb begin
        regs_d         = regs_q;
        wr_count_d     = wr_count_q;
        last_wr_addr_d = last_wr_addr_q;
        if (wr_commit) begin
            regs_d[wr_addr_i] = wr_data_i;
            wr_count_d        = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
            last_wr_addr_d    = wr_addr_i;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegs; i++) begin
                if (i == 28) begin
                    regs_q[i] <= GP_INIT;
                end else if (i == 29) begin
                    regs_q[i] <= SP_INIT;
                end else begin
                    regs_q[i] <= '0;
                end
            end
            wr_count_q     <= '0;
            last_wr_addr_q <= '0;
        end else begin
            regs_q         <= regs_d;
            wr_count_q     <= wr_count_d;
            last_wr_addr_q <= last_wr_addr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            rd[i] = regs_q[i];
`ifdef WRITE_FWD_EN
            if (rst_ni && wr_commit && (wr_addr_i == SIZE'(i))) begin
                rd[i] = wr_data_i;
            end
`endif
        end
        rd[0] = '0;
    end

    assign q0_o  = rd[0];
    assign q1_o  = rd[1];
    assign q2_o  = rd[2];
    assign q3_o  = rd[3];
    assign q4_o  = rd[4];
    assign q5_o  = rd[5];
    assign q6_o  = rd[6];
    assign q7_o  = rd[7];
    assign q8_o  = rd[8];
    assign q9_o  = rd[9];
    assign q10_o = rd[10];
    assign q11_o = rd[11];
    assign q12_o = rd[12];
    assign q13_o = rd[13];
    assign q14_o = rd[14];
    assign q15_o = rd[15];
    assign q16_o = rd[16];
    assign q17_o = rd[17];
    assign q18_o = rd[18];
    assign q19_o = rd[19];
    assign q20_o = rd[20];
    assign q21_o = rd[21];
    assign q22_o = rd[22];
    assign q23_o = rd[23];
    assign q24_o = rd[24];
    assign q25_o = rd[25];
    assign q26_o = rd[26];
    assign q27_o = rd[27];
    assign q28_o = rd[28];
    assign q29_o = rd[29];
    assign q30_o = rd[30];
    assign q31_o = rd[31];

    assign wr_count_o     = wr_count_q;
    assign last_wr_addr_o = last_wr_addr_q;

endmodule

// File: tb/tb_register_bank32.sv
// Scoreboard bench for register_bank32: expected snapshots are queued by the stimulus
// and compared by a separate monitor against an array-based reference model.
module tb_register_bank32;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] q [32];
    logic [15:0] wr_count;
    logic [4:0]  last_wr_addr;

    typedef struct {
        string              name;
        logic [31:0][31:0]  qv;
        logic [15:0]        cnt;
        logic [4:0]         last;
    } exp_t;

    exp_t        exp_q[$];
    event        sample_ev;
    int          errors = 0;
    int          checks = 0;

    logic [31:0] model [32];
    int          model_cnt;
    logic [4:0]  model_last;

    register_bank32 dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .q0_o(q[0]),   .q1_o(q[1]),   .q2_o(q[2]),   .q3_o(q[3]),
        .q4_o(q[4]),   .q5_o(q[5]),   .q6_o(q[6]),   .q7_o(q[7]),
        .q8_o(q[8]),   .q9_o(q[9]),   .q10_o(q[10]), .q11_o(q[11]),
        .q12_o(q[12]), .q13_o(q[13]), .q14_o(q[14]), .q15_o(q[15]),
        .q16_o(q[16]), .q17_o(q[17]), .q18_o(q[18]), .q19_o(q[19]),
        .q20_o(q[20]), .q21_o(q[21]), .q22_o(q[22]), .q23_o(q[23]),
        .q24_o(q[24]), .q25_o(q[25]), .q26_o(q[26]), .q27_o(q[27]),
        .q28_o(q[28]), .q29_o(q[29]), .q30_o(q[30]), .q31_o(q[31]),
        .wr_count_o(wr_count), .last_wr_addr_o(last_wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[28]  = 32'h1000_8000;
        model[29]  = 32'h7FFF_EFFC;
        model_cnt  = 0;
        model_last = 5'd0;
    endfunction

    function automatic void model_write(input logic en, input logic [4:0] a, input logic [31:0] d);
        if (en && a != 5'd0) begin
            model[a]   = d;
            model_cnt  = (model_cnt < 65535) ? model_cnt + 1 : 65535;
            model_last = a;
        end
    endfunction

    // Monitor: drains every queued expectation when the stimulus signals a sample point.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < 32; i++) begin
                    checks++;
                    if (q[i] !== e.qv[i]) begin
                        errors++;
                        $display("FAIL %s q%0d: got %h, required %h", e.name, i, q[i], e.qv[i]);
                    end
                end
                checks++;
                if (wr_count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s wr_count: got %h, required %h", e.name, wr_count, e.cnt);
                end
                checks++;
                if (last_wr_addr !== e.last) begin
                    errors++;
                    $display("FAIL %s last_wr_addr: got %0d, required %0d", e.name,
                             last_wr_addr, e.last);
                end
            end
        end
    end

    task automatic check_now(input string name, input logic fwd, input logic [4:0] a,
                             input logic [31:0] d);
        exp_t e;
        e.name = name;
        for (int i = 0; i < 32; i++) e.qv[i] = model[i];
`ifdef WRITE_FWD_EN
        if (fwd && rst_n && a != 5'd0) e.qv[a] = d;
`else
        if (fwd && a == 5'd31 && d == 32'h0) e.name = {name, "_"};
`endif
        e.cnt  = 16'(model_cnt);
        e.last = model_last;
        exp_q.push_back(e);
        -> sample_ev;
        for (int k = 0; k < 2 && exp_q.size() != 0; k++) #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s monitor_timeout: got %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_write(input string name, input logic en, input logic [4:0] a,
                            input logic [31:0] d, input bit chk);
        @(negedge clk);
        wr_en = en; wr_addr = a; wr_data = d;
        if (chk) begin
            #1;
            check_now({name, "_pre"}, en, a, d);
        end
        @(posedge clk);
        model_write(en, a, d);
        if (chk) begin
            #1;
            check_now({name, "_post"}, 1'b0, 5'd0, 32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_now("reset_init", 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_write("basic_r5", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
        do_write("r0_drop", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
        do_write("b2b_a", 1'b1, 5'd31, 32'd1, 1'b1);
        do_write("b2b_b", 1'b1, 5'd31, 32'd2, 1'b1);
        do_write("b2b_c", 1'b1, 5'd1, 32'd3, 1'b1);
        do_write("fwd_r7", 1'b1, 5'd7, 32'h0000_1234, 1'b1);
        do_write("hold", 1'b0, 5'd9, 32'hCAFE_F00D, 1'b1);
        do_write("gp_write", 1'b1, 5'd28, 32'hA5A5_5A5A, 1'b1);

        for (int n = 0; n < 300; n++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            do_write("rand", 1'($urandom_range(0, 3) != 0), a, $urandom, 1'b1);
        end

        // Reset mid-cycle while a write is being presented.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h5555_AAAA;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_now("async_reset", 1'b1, 5'd3, 32'h5555_AAAA);
        @(posedge clk);
        #1 check_now("reset_holds_edge", 1'b1, 5'd3, 32'h5555_AAAA);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        do_write("first_after_reset", 1'b1, 5'd3, 32'h0BAD_F00D, 1'b1);

        for (int n = 0; n < 65533; n++) do_write("sat_fill", 1'b1, 5'd2, 32'(n), 1'b0);
        do_write("sat_reach", 1'b1, 5'd2, 32'h1111_2222, 1'b1);
        do_write("sat_hold", 1'b1, 5'd2, 32'h3333_4444, 1'b1);
        do_write("sat_r0", 1'b1, 5'd0, 32'h7777_8888, 1'b1);

        @(negedge clk);
        wr_en = 1'b0;
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_now("sat_reset", 1'b0, 5'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_bank32.md
# register_bank32

32-entry by WIDTH-bit general-purpose register storage for the datapath. It sits directly upstream of the 32-to-1 read multiplexers and presents all 32 register values in parallel on q0..q31 so that each read port can select one by register number. It accepts one synchronous write per clock from the write-back stage. Register 0 is hardwired to zero, and the gp and sp registers reset to nonzero pointer values.

## Interface
Parameters:
- WIDTH, 32, data width of each register.
- SIZE, 5, register-address width; the register count is fixed at 32.
- GP_INIT, 32'h1000_8000, reset value of register 28 (gp).
- SP_INIT, 32'h7FFF_EFFC, reset value of register 29 (sp).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write enable, sampled on the rising clk edge.
- wr_addr  input  SIZE  destination register number.
- wr_data  input  WIDTH  write data.
- q0 .. q31  output  WIDTH each  current contents of registers 0..31, feeding the read multiplexers.
- wr_count  output  16  number of committed writes since reset; saturates at 16'hFFFF.
- last_wr_addr  output  SIZE  destination of the most recent committed write.

## Operation
- Reset (reset=0, asynchronous):
  - All registers clear to 0, except register 28 = GP_INIT and register 29 = SP_INIT.
  - wr_count = 0 and last_wr_addr = 0.
  - Reset overrides a write in progress; no partial update of any register.
- Write:
  - On the rising clk edge with reset=1, wr_en=1 and wr_addr≠0, register[wr_addr] takes wr_data.
  - On the same edge, wr_count increments (saturating at 16'hFFFF) and last_wr_addr takes wr_addr.
- Writes to register 0:
  - Discarded. q0 is constant 0 at all times.
  - wr_count and last_wr_addr are not updated.
- With wr_en=0, all state holds.
- Only one write port, so there are no write collisions. Registers 28 and 29 are writable like any other register.
- Outputs q1..q31 come directly from the storage flops. Their combinational form depends on the configuration option below.
- wr_count saturation: at 16'hFFFF, further committed writes leave the count at 16'hFFFF and do not wrap.

## Timing
- Write latency: data written at rising edge N appears on q[wr_addr] after edge N. The read multiplexer sees it in cycle N+1 (without the forwarding option).
- wr_count and last_wr_addr update on the same edge as the register write.
- Reset assertion takes effect immediately, with no clock required. The first write can commit on the first rising edge after reset deasserts.
- The block places no setup requirement on wr_addr or wr_data beyond normal flop setup to clk.

## Configuration
- WRITE_FWD_EN:
  - Defined: while reset=1 and wr_en=1, the output q[wr_addr] for wr_addr≠0 shows wr_data combinationally in the current cycle (write-before-read). A same-cycle read through the mux therefore returns the new value. Storage still updates on the edge. q0 stays 0.
  - Not defined: outputs reflect only stored state, and the new value is visible after the edge.

## Test plan
- Reset values: drive reset=0 mid-cycle with wr_en=1 -> immediately q28=32'h1000_8000, q29=32'h7FFF_EFFC, all other q=0, wr_count=0, last_wr_addr=0.
- Basic write: wr_en=1, wr_addr=5, wr_data=32'hDEAD_BEEF for one edge -> q5=32'hDEAD_BEEF after the edge, all other registers unchanged, wr_count=1, last_wr_addr=5.
- Register 0 protection: wr_en=1, wr_addr=0, wr_data=32'hFFFF_FFFF -> q0 stays 0, and wr_count and last_wr_addr are unchanged.
- Back-to-back writes: write r31=1, r31=2, r1=3 on consecutive edges -> q31=2, q1=3, wr_count=3, last_wr_addr=1.
- Forwarding:
  - With WRITE_FWD_EN defined: wr_en=1, wr_addr=7, wr_data=32'h1234 -> q7=32'h1234 in the same cycle, before the edge.
  - Without WRITE_FWD_EN: q7 keeps its old value until after the edge.
- Saturation and reset: force 65536 writes to r2 -> wr_count=16'hFFFF. Assert reset -> wr_count=0 and q2=0.
